// File: rtl/piezo_sequencer.sv
// Melody/keyboard sequencer for a piezo tone generator: plays notes 0..SEQ_LEN-1 with gaps,
// or sounds the held key when idle. All outputs are registered.
module piezo_sequencer #(
  parameter int unsigned TICK_DIV = 1000,
  parameter int unsigned NOTE_MS  = 250,
  parameter int unsigned GAP_MS   = 50,
  parameter int unsigned SEQ_LEN  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        key_valid,
  input  logic [2:0]  key_note,
  output logic        tone_en,
  output logic [10:0] half_period,
  output logic [2:0]  note_idx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned PresW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DurMax = (NOTE_MS > GAP_MS) ? NOTE_MS : GAP_MS;
  localparam int unsigned DurW   = (DurMax > 1) ? $clog2(DurMax) : 1;

  localparam logic [PresW-1:0] PresLast = PresW'(TICK_DIV - 1);
  localparam logic [DurW-1:0]  NoteLast = DurW'(NOTE_MS - 1);
  localparam logic [DurW-1:0]  GapLast  = DurW'(GAP_MS - 1);
  localparam logic [2:0]       IdxLast  = 3'(SEQ_LEN - 1);

  typedef enum logic [1:0] {StIdle, StNote, StGap, StKey} state_e;

  state_e           r_state, w_state_d;
  logic [PresW-1:0] r_pres, w_pres_d;
  logic [DurW-1:0]  r_dur, w_dur_d;
  logic             r_tone, w_tone_d;
  logic [10:0]      r_hp, w_hp_d;
  logic [2:0]       r_idx, w_idx_d;
  logic             r_busy;
  logic             r_done, w_done_d;
  logic             w_tick;

  function automatic logic [10:0] note_hp(input logic [2:0] code);
    logic [10:0] hp;
    case (code)
      3'd0:    hp = 11'd1915;
      3'd1:    hp = 11'd1700;
      3'd2:    hp = 11'd1519;
      3'd3:    hp = 11'd1432;
      3'd4:    hp = 11'd1275;
      3'd5:    hp = 11'd1136;
      3'd6:    hp = 11'd1014;
      default: hp = 11'd956;
    endcase
    return hp;
  endfunction

  assign w_tick = (r_pres == PresLast);

  always_comb begin
    w_state_d = r_state;
    w_pres_d  = '0;
    w_dur_d   = '0;
    w_tone_d  = r_tone;
    w_hp_d    = r_hp;
    w_idx_d   = r_idx;
    w_done_d  = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_state_d = StNote;
          w_tone_d  = 1'b1;
          w_hp_d    = note_hp(3'd0);
          w_idx_d   = 3'd0;
        end else if (key_valid) begin
          w_state_d = StKey;
          w_tone_d  = 1'b1;
          w_hp_d    = note_hp(key_note);
        end
      end
      StNote: begin
        w_pres_d = w_tick ? '0 : r_pres + 1'b1;
        w_dur_d  = w_tick ? r_dur + 1'b1 : r_dur;
        if (stop) begin
          w_state_d = StIdle;
          w_tone_d  = 1'b0;
          w_hp_d    = '0;
          w_idx_d   = '0;
        end else if (w_tick && (r_dur == NoteLast)) begin
          w_state_d = StGap;
          w_tone_d  = 1'b0;
        end
      end
      StGap: begin
        w_pres_d = w_tick ? '0 : r_pres + 1'b1;
        w_dur_d  = w_tick ? r_dur + 1'b1 : r_dur;
        // stop takes precedence over a coinciding gap end, so no done pulse
        if (stop) begin
          w_state_d = StIdle;
          w_tone_d  = 1'b0;
          w_hp_d    = '0;
          w_idx_d   = '0;
        end else if (w_tick && (r_dur == GapLast)) begin
          if (r_idx == IdxLast) begin
            w_state_d = StIdle;
            w_tone_d  = 1'b0;
            w_hp_d    = '0;
            w_idx_d   = '0;
            w_done_d  = 1'b1;
          end else begin
            w_state_d = StNote;
            w_tone_d  = 1'b1;
            w_idx_d   = r_idx + 3'd1;
            w_hp_d    = note_hp(r_idx + 3'd1);
          end
        end
      end
      StKey: begin
        if (!key_valid) begin
          w_state_d = StIdle;
          w_tone_d  = 1'b0;
          w_hp_d    = '0;
          w_idx_d   = '0;
        end else begin
          w_hp_d = note_hp(key_note);
        end
      end
      default: w_state_d = StIdle;
    endcase

    // Both counters restart on every state entry
    if (w_state_d != r_state) begin
      w_pres_d = '0;
      w_dur_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= StIdle;
      r_pres  <= '0;
      r_dur   <= '0;
      r_tone  <= 1'b0;
      r_hp    <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_pres  <= w_pres_d;
      r_dur   <= w_dur_d;
      r_tone  <= w_tone_d;
      r_hp    <= w_hp_d;
      r_idx   <= w_idx_d;
      r_busy  <= (w_state_d != StIdle);
      r_done  <= w_done_d;
    end
  end

  assign tone_en     = r_tone;
  assign half_period = r_hp;
  assign note_idx    = r_idx;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_piezo_sequencer.sv
// Directed bench for piezo_sequencer: SEQ_LEN=3 instance for the main scenarios and a
// SEQ_LEN=1 instance sharing the same stimulus for the single-note boundary.
module tb_piezo_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        key_valid = 1'b0;
  logic [2:0]  key_note = 3'd0;

  logic        tone_en3, busy3, done3;
  logic [10:0] hp3;
  logic [2:0]  idx3;
  logic        tone_en1, busy1, done1;
  logic [10:0] hp1;
  logic [2:0]  idx1;

  logic [16:0] obs3, obs1;
  assign obs3 = {tone_en3, hp3, idx3, busy3, done3};
  assign obs1 = {tone_en1, hp1, idx1, busy1, done1};

  int errors = 0;
  int checks = 0;

  logic [10:0] hp_tab [8] = '{11'd1915, 11'd1700, 11'd1519, 11'd1432,
                              11'd1275, 11'd1136, 11'd1014, 11'd956};

  always #5 clk = ~clk;

  piezo_sequencer #(.TICK_DIV(4), .NOTE_MS(2), .GAP_MS(1), .SEQ_LEN(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .key_valid(key_valid),
    .key_note(key_note), .tone_en(tone_en3), .half_period(hp3), .note_idx(idx3),
    .busy(busy3), .done(done3)
  );

  piezo_sequencer #(.TICK_DIV(4), .NOTE_MS(2), .GAP_MS(1), .SEQ_LEN(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .key_valid(key_valid),
    .key_note(key_note), .tone_en(tone_en1), .half_period(hp1), .note_idx(idx1),
    .busy(busy1), .done(done1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs k cycles after start was sampled, for a 3-note melody (12 cycles per note)
  function automatic logic [16:0] melody_exp(input int k);
    int n, seg;
    n = k / 12;
    seg = k % 12;
    if (k < 36) return {(seg < 8) ? 1'b1 : 1'b0, hp_tab[n], 3'(n), 2'b10};
    else if (k == 36) return 17'd1;
    else return 17'd0;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    checks++;
    if (obs3 !== 17'd0) begin
      errors++;
      $display("FAIL reset_dut3 got=%h exp=%h", obs3, 17'd0);
    end
    checks++;
    if (obs1 !== 17'd0) begin
      errors++;
      $display("FAIL reset_dut1 got=%h exp=%h", obs1, 17'd0);
    end
    rst = 1'b1;
  endtask

  task automatic test_full_melody();
    logic [16:0] exp;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 38; k++) begin
      if (k > 0) step();
      exp = melody_exp(k);
      checks++;
      if (obs3 !== exp) begin
        errors++;
        $display("FAIL melody k=%0d got=%h exp=%h", k, obs3, exp);
      end
    end
  endtask

  task automatic test_abort();
    logic seen_done;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 14; k++) step();
    checks++;
    if (obs3 !== {1'b1, 11'd1700, 3'd1, 2'b10}) begin
      errors++;
      $display("FAIL abort_pre got=%h exp=%h", obs3, {1'b1, 11'd1700, 3'd1, 2'b10});
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if (obs3 !== 17'd0) begin
      errors++;
      $display("FAIL abort_idle got=%h exp=%h", obs3, 17'd0);
    end
    seen_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (done3 !== 1'b0) seen_done = 1'b1;
    end
    checks++;
    if (seen_done !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done got=%b exp=%b", seen_done, 1'b0);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (obs3 !== {1'b1, 11'd1915, 3'd0, 2'b10}) begin
      errors++;
      $display("FAIL abort_restart got=%h exp=%h", obs3, {1'b1, 11'd1915, 3'd0, 2'b10});
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_key();
    key_valid = 1'b1;
    key_note = 3'd4;
    step();
    checks++;
    if (obs3 !== {1'b1, 11'd1275, 3'd0, 2'b10}) begin
      errors++;
      $display("FAIL key4 got=%h exp=%h", obs3, {1'b1, 11'd1275, 3'd0, 2'b10});
    end
    key_note = 3'd7;
    step();
    checks++;
    if (obs3 !== {1'b1, 11'd956, 3'd0, 2'b10}) begin
      errors++;
      $display("FAIL key7 got=%h exp=%h", obs3, {1'b1, 11'd956, 3'd0, 2'b10});
    end
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    checks++;
    if (obs3 !== {1'b1, 11'd956, 3'd0, 2'b10}) begin
      errors++;
      $display("FAIL key_ignore_start_stop got=%h exp=%h", obs3, {1'b1, 11'd956, 3'd0, 2'b10});
    end
    key_valid = 1'b0;
    step();
    checks++;
    if (obs3 !== 17'd0) begin
      errors++;
      $display("FAIL key_release got=%h exp=%h", obs3, 17'd0);
    end
  endtask

  task automatic test_priority();
    logic [16:0] exp;
    start = 1'b1;
    key_valid = 1'b1;
    key_note = 3'd5;
    step();
    start = 1'b0;
    for (int k = 0; k < 38; k++) begin
      if (k > 0) step();
      exp = (k == 37) ? {1'b1, 11'd1136, 3'd0, 2'b10} : melody_exp(k);
      checks++;
      if (obs3 !== exp) begin
        errors++;
        $display("FAIL priority k=%0d got=%h exp=%h", k, obs3, exp);
      end
    end
    key_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_midop();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 9; k++) step();
    checks++;
    if (obs3 !== {1'b0, 11'd1915, 3'd0, 2'b10}) begin
      errors++;
      $display("FAIL rstmid_gap got=%h exp=%h", obs3, {1'b0, 11'd1915, 3'd0, 2'b10});
    end
    rst = 1'b0;
    step();
    checks++;
    if (obs3 !== 17'd0) begin
      errors++;
      $display("FAIL rstmid_zero got=%h exp=%h", obs3, 17'd0);
    end
    rst = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (obs3 !== {1'b1, 11'd1915, 3'd0, 2'b10}) begin
      errors++;
      $display("FAIL rstmid_restart got=%h exp=%h", obs3, {1'b1, 11'd1915, 3'd0, 2'b10});
    end
    for (int k = 1; k <= 20; k++) step();
    checks++;
    if (obs3 !== {1'b0, 11'd1700, 3'd1, 2'b10}) begin
      errors++;
      $display("FAIL rstmid_k20 got=%h exp=%h", obs3, {1'b0, 11'd1700, 3'd1, 2'b10});
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  task automatic test_seq_len_one();
    logic [16:0] exp;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 14; k++) begin
      if (k > 0) begin
        start = (k == 10);
        step();
        start = 1'b0;
      end
      if (k < 8) exp = {1'b1, 11'd1915, 3'd0, 2'b10};
      else if (k < 12) exp = {1'b0, 11'd1915, 3'd0, 2'b10};
      else if (k == 12) exp = 17'd1;
      else exp = 17'd0;
      checks++;
      if (obs1 !== exp) begin
        errors++;
        $display("FAIL seq1 k=%0d got=%h exp=%h", k, obs1, exp);
      end
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_melody();
    test_abort();
    test_key();
    test_priority();
    test_reset_midop();
    test_seq_len_one();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
